add_sub_serial: RTL
===================

Name: add_sub_serial

Overview:
- Parametrised multi-cycle two's-complement adder/subtractor; successor to the combinational N-bit ripple add/sub with cOut/cPenult.
- Processes N-bit operands CHUNK bits per clock, holding the carry in a register between slices. This gives a narrow carry chain for the floating-point mantissa datapath.
- Adds a valid/ready handshake on both sides, a registered signed-overflow flag and an optional saturation mode.

Parameters:
N, 16, operand/result width; must be a multiple of CHUNK, N >= 2
CHUNK, 4, bits added per clock; 1 <= CHUNK <= N
NCH (localparam), N/CHUNK, compute cycles per operation

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
inValid  in  1  operands a/b/op/sat presented
inReady  out  1  block can accept operands this cycle
a  in  N  operand A
b  in  N  operand B
op  in  1  0 = a+b, 1 = a-b
sat  in  1  1 = saturate result on signed overflow
outValid  out  1  result/flags valid and held
outReady  in  1  consumer takes result this cycle
c  out  N  result
cOut  out  1  carry out of bit N-1 (raw, before saturation)
cPenult  out  1  carry into bit N-1
ovf  out  1  signed overflow = cOut ^ cPenult

Behaviour:
- Reset (synchronous, active-high): state = IDLE. c, cOut, cPenult, ovf, outValid and the chunk counter all go to 0.
- Reset mid-operation: the in-flight operation is discarded and no result is produced.
- FSM states: IDLE, COMPUTE, DONE.
- inReady = (state==IDLE) | (state==DONE & outReady). This is combinational.
- Accept: occurs on an edge where inValid & inReady.
  - a, b (inverted if op=1), sat and carry-in (= op) are captured into internal registers.
  - The chunk counter is set to 0 and state goes to COMPUTE.
  - Inputs may change freely after acceptance.
- COMPUTE: each edge adds slice [k*CHUNK +: CHUNK] of the captured operands plus the carry register.
  - The slice sum is written into the result register and the carry register is updated.
  - At the slice containing bit N-1, cPenult is recorded as the carry into bit N-1.
  - After slice NCH-1 (the NCH-th compute edge), the final result is written:
    - cOut = final carry.
    - ovf = cOut ^ cPenult.
    - If sat & ovf, c = cOut ? {1'b1,{N-1{0}}} (min) : {1'b0,{N-1{1}}} (max). Otherwise c = raw sum.
    - outValid goes to 1 and state goes to DONE.
- Latency: outValid is first high in the cycle after the NCH-th edge following acceptance. CHUNK==N gives 1 compute cycle.
- DONE: c/cOut/cPenult/ovf/outValid are held stable until outReady.
  - outReady & inValid: the result is consumed and new operands are accepted on the same edge. outValid goes to 0 and state goes to COMPUTE, giving back-to-back throughput of one result per NCH+1 cycles.
  - outReady & !inValid: outValid goes to 0 and state goes to IDLE.
- Flag outputs are valid only while outValid=1. Their values persist until the next final-slice edge or reset.
- cOut/cPenult are for unsigned use. For subtraction, cOut=1 means no borrow (a >= b unsigned).
- Intermediate slice results are not visible on c before the DONE state; internal registers are used until the final edge.

Test Plan:
1. N=4, CHUNK=2, a=0110, b=0110, op=0, sat=0 -> after 2 compute edges: c=1100, cOut=0, cPenult=1, ovf=1. Repeat with sat=1 -> c=0111.
2. N=4, CHUNK=2, a=0100, b=0111, op=1 -> c=1101, cOut=0, cPenult=0, ovf=0. Then a=0110, b=0101, op=1 -> c=0001, cOut=1, cPenult=1, ovf=0.
3. N=4, CHUNK=1, a=1000, b=0001, op=1, sat=1 -> ovf=1, cOut=1, c=1000 (min). Confirm outValid rises exactly 4 edges after acceptance.
4. Backpressure: hold outReady=0 for 5 cycles -> c and flags stable, inReady=0, inValid ignored. Then assert outReady with inValid=1 -> new operands accepted on the same edge, outValid drops for NCH cycles.
5. Reset mid-operation: assert reset on the edge after acceptance -> next cycle state is IDLE, outValid=0, c=0, inReady=1, and no result appears afterwards.
6. Defaults N=16, CHUNK=4: random a/b/op/sat stream with random outReady -> every result matches a reference model (sum, cOut, cPenult, ovf, saturation), each with latency 4.

Source files
------------

// File: rtl/add_sub_serial.sv
// add_sub_serial: multi-cycle two's-complement add/sub, CHUNK bits per clock, valid/ready on both sides
module add_sub_serial #(
    parameter int N     = 16,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inValid,
    output logic         inReady,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         op,
    input  logic         sat,
    output logic         outValid,
    input  logic         outReady,
    output logic [N-1:0] c,
    output logic         cOut,
    output logic         cPenult,
    output logic         ovf
);
    localparam int NCH = N / CHUNK;
    localparam int CW  = NCH > 1 ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t           state, state_n;
    logic [N-1:0]     ra, rb, acc, sum_n;
    logic [CHUNK-1:0] s;
    logic [CW-1:0]    cnt;
    logic             rsat, carry, cy, cp, ov, accept, last;

    assign inReady = (state == IDLE) | (state == DONE & outReady);

    // Slice adder, merged partial sum, final-slice flags and next state.
    // Carry into bit N-1 is recovered from the top sum bit: s = a ^ b ^ cin.
    always_comb begin
        accept = inValid & inReady;
        last = cnt == CW'(NCH - 1);
        {cy, s} = {1'b0, ra[cnt*CHUNK +: CHUNK]} + {1'b0, rb[cnt*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, carry};
        sum_n = acc;
        sum_n[cnt*CHUNK +: CHUNK] = s;
        cp = s[CHUNK-1] ^ ra[N-1] ^ rb[N-1];
        ov = cy ^ cp;
        state_n = (state == COMPUTE) ? (last ? DONE : COMPUTE) :
                  accept ? COMPUTE :
                  (state == DONE && outReady) ? IDLE : state;
    end

    // Operand capture, per-slice accumulation and the registered result/flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            carry    <= 1'b0;
            acc      <= '0;
            c        <= '0;
            cOut     <= 1'b0;
            cPenult  <= 1'b0;
            ovf      <= 1'b0;
            outValid <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                ra    <= a;
                rb    <= op ? ~b : b;
                rsat  <= sat;
                carry <= op;
                cnt   <= '0;
                acc   <= '0;
            end else if (state == COMPUTE) begin
                acc   <= sum_n;
                carry <= cy;
                cnt   <= cnt + 1'b1;
            end
            if (state == COMPUTE && last) begin
                c        <= (rsat && ov) ? (cy ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}}) : sum_n;
                cOut     <= cy;
                cPenult  <= cp;
                ovf      <= ov;
                outValid <= 1'b1;
            end else if (state == DONE && outReady) begin
                outValid <= 1'b0;
            end
        end
    end
endmodule
